// File: rtl/sync_word_pkg.sv
// Shared constants, types and sizing helpers for the sync-word streamer.
package sync_word_pkg;

  // Width of the sync_word input port; the carrier count can only trim this.
  localparam int SYNC_WORD_BITS        = 800;
  localparam int USED_CARRIERS_DEFAULT = 800;
  localparam int WORD_WIDTH            = 32;

  // Number of output words needed to carry all valid carriers.
  function automatic int num_words(input int carriers, input int width);
    return (carriers + width - 1) / width;
  endfunction

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

endpackage

// File: rtl/sync_word_streamer.sv
// Streams a snapshot of the sync word as an AXI-Stream burst, optionally
// repeated, with tlast marking the end of each pass.
//
// state  | meaning
// -------+-----------------------------------------------------------------
// IDLE   | waiting for start; outputs quiet
// STREAM | presenting snapshot[word_idx], advancing on each handshake
module sync_word_streamer
  import sync_word_pkg::*;
#(
  parameter int USED_CARRIERS      = USED_CARRIERS_DEFAULT,
  parameter int M_AXIS_TDATA_WIDTH = WORD_WIDTH
) (
  input  logic                          m_axis_sync_aclk,
  input  logic                          m_axis_sync_aresetn,
  input  logic [SYNC_WORD_BITS-1:0]     sync_word,
  input  logic                          start,
  input  logic [3:0]                    repeat_count,
  output logic [M_AXIS_TDATA_WIDTH-1:0] m_axis_sync_tdata,
  output logic                          m_axis_sync_tvalid,
  input  logic                          m_axis_sync_tready,
  output logic                          m_axis_sync_tlast,
  output logic                          busy,
  output logic                          done
);

  localparam int NUM_WORDS = num_words(USED_CARRIERS, M_AXIS_TDATA_WIDTH);
  localparam int SNAP_BITS = NUM_WORDS * M_AXIS_TDATA_WIDTH;
  localparam int IDX_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

  // Carriers past USED_CARRIERS are cleared at capture so the final partial
  // word goes out zero-padded without any per-word masking.
  localparam logic [SNAP_BITS-1:0] CARRIER_MASK =
    {SNAP_BITS{1'b1}} >> (SNAP_BITS - USED_CARRIERS);

  state_t                 state;
  logic [SNAP_BITS-1:0]   snapshot;
  logic [SNAP_BITS-1:0]   snap_next;
  logic [IDX_W-1:0]       word_idx;
  logic [3:0]             pass_cnt;
  logic [3:0]             rep_snap;
  logic                   handshake;
  logic                   last_word;
  logic                   last_pass;

  assign snap_next = SNAP_BITS'(sync_word) & CARRIER_MASK;
  assign handshake = (state == STREAM) && m_axis_sync_tready;
  assign last_word = (word_idx == LAST_IDX);
  assign last_pass = (pass_cnt == rep_snap);

  // Sequencer: capture on start, walk words and passes on each handshake.
  always_ff @(posedge m_axis_sync_aclk or negedge m_axis_sync_aresetn) begin
    if (!m_axis_sync_aresetn) begin
      state    <= IDLE;
      snapshot <= '0;
      word_idx <= '0;
      pass_cnt <= '0;
      rep_snap <= '0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            snapshot <= snap_next;
            rep_snap <= repeat_count;
            word_idx <= '0;
            pass_cnt <= '0;
            state    <= STREAM;
          end
        end
        STREAM: begin
          if (handshake) begin
            if (last_word) begin
              word_idx <= '0;
              if (last_pass) begin
                pass_cnt <= '0;
                done     <= 1'b1;
                state    <= IDLE;
              end else begin
                pass_cnt <= pass_cnt + 4'd1;
              end
            end else begin
              word_idx <= word_idx + IDX_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs decode registered state only, so tready never reaches them
  // combinationally and data/last hold naturally during a stall.
  always_comb begin
    m_axis_sync_tvalid = (state == STREAM);
    busy               = (state == STREAM);
    m_axis_sync_tlast  = (state == STREAM) && last_word;
    m_axis_sync_tdata  = '0;
    if (state == STREAM) begin
      m_axis_sync_tdata = snapshot[word_idx * M_AXIS_TDATA_WIDTH +: M_AXIS_TDATA_WIDTH];
    end
  end

endmodule

// File: tb/tb_sync_word_streamer.sv
// Scoreboard bench for sync_word_streamer: stimulus pushes expected words,
// a negedge monitor pops and compares on every handshake.
module tb_sync_word_streamer;

  localparam int NW = 25;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [799:0] sync_word;
  logic         start = 1'b0;
  logic [3:0]   repeat_count = 4'd0;
  logic         tready = 1'b1;
  logic [31:0]  tdata;
  logic         tvalid, tlast, busy, done;

  logic [799:0] sw790 = '1;
  logic         start790 = 1'b0;
  logic         tready790 = 1'b1;
  logic [31:0]  tdata790;
  logic         tvalid790, tlast790, busy790, done790;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
    logic        fin;
  } exp_t;

  exp_t        q[$];
  int          errors = 0;
  int          checks = 0;
  int          hs_cnt = 0;
  int          done_cnt = 0;
  int          tr_mode = 0;
  logic [7:0]  lfsr = 8'hA7;

  always #5 clk = ~clk;

  sync_word_streamer dut (
    .m_axis_sync_aclk    (clk),
    .m_axis_sync_aresetn (rst_n),
    .sync_word           (sync_word),
    .start               (start),
    .repeat_count        (repeat_count),
    .m_axis_sync_tdata   (tdata),
    .m_axis_sync_tvalid  (tvalid),
    .m_axis_sync_tready  (tready),
    .m_axis_sync_tlast   (tlast),
    .busy                (busy),
    .done                (done)
  );

  sync_word_streamer #(.USED_CARRIERS(790)) dut790 (
    .m_axis_sync_aclk    (clk),
    .m_axis_sync_aresetn (rst_n),
    .sync_word           (sw790),
    .start               (start790),
    .repeat_count        (4'd0),
    .m_axis_sync_tdata   (tdata790),
    .m_axis_sync_tvalid  (tvalid790),
    .m_axis_sync_tready  (tready790),
    .m_axis_sync_tlast   (tlast790),
    .busy                (busy790),
    .done                (done790)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // tready source: constant high, or pseudo-random backpressure
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (tr_mode == 1) begin
        lfsr   = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        tready = lfsr[0];
      end else begin
        tready = 1'b1;
      end
    end
  end

  // Monitor: protocol rules every cycle, scoreboard pop on each handshake
  initial begin
    logic        prev_valid;
    logic        prev_hs;
    logic        prev_fin;
    logic        prev_last;
    logic [31:0] prev_data;
    exp_t        e;
    prev_valid = 1'b0; prev_hs = 1'b0; prev_fin = 1'b0;
    prev_last = 1'b0; prev_data = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_valid = 1'b0; prev_hs = 1'b0; prev_fin = 1'b0;
      end else begin
        check("done_pulse", {31'd0, done}, {31'd0, prev_fin});
        if (done) done_cnt++;
        if (prev_fin) begin
          check("end_tvalid", {31'd0, tvalid}, 32'd0);
          check("end_tlast", {31'd0, tlast}, 32'd0);
          check("end_busy", {31'd0, busy}, 32'd0);
        end
        check("busy_vs_tvalid", {31'd0, busy}, {31'd0, tvalid});
        if (prev_valid && !prev_fin) check("no_bubble", {31'd0, tvalid}, 32'd1);
        if (prev_valid && !prev_hs && tvalid) begin
          check("stall_tdata", tdata, prev_data);
          check("stall_tlast", {31'd0, tlast}, {31'd0, prev_last});
        end
        prev_hs  = 1'b0;
        prev_fin = 1'b0;
        if (tvalid && tready) begin
          if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_word: got %h expected no word", tdata);
          end else begin
            e = q.pop_front();
            check("tdata", tdata, e.data);
            check("tlast", {31'd0, tlast}, {31'd0, e.last});
            prev_fin = e.fin;
          end
          prev_hs = 1'b1;
          hs_cnt++;
        end
        prev_valid = tvalid;
        prev_data  = tdata;
        prev_last  = tlast;
      end
    end
  end

  task automatic load_pattern();
    for (int k = 0; k < NW; k++) sync_word[32*k +: 32] = 32'hA500_0000 + 32'(k);
  endtask

  task automatic push_passes(input int passes);
    exp_t e;
    for (int p = 0; p < passes; p++) begin
      for (int k = 0; k < NW; k++) begin
        e.data = 32'hA500_0000 + 32'(k);
        e.last = (k == NW - 1);
        e.fin  = (p == passes - 1) && (k == NW - 1);
        q.push_back(e);
      end
    end
  endtask

  task automatic pulse_start(input logic [3:0] rep);
    @(posedge clk);
    #1;
    repeat_count = rep;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    check("start_latency_tvalid", {31'd0, tvalid}, 32'd1);
    check("start_latency_word0", tdata, 32'hA500_0000);
  endtask

  task automatic wait_stream(input string name, input int want_done, input int budget);
    int n;
    n = 0;
    while ((q.size() != 0 || done_cnt < want_done) && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL %s_timeout: got %0d words pending expected 0", name, q.size());
    end
    repeat (3) @(negedge clk);
    check({name, "_done_count"}, 32'(done_cnt), 32'(want_done));
  endtask

  task automatic wait_words(input int n_words);
    int n;
    n = 0;
    while (hs_cnt < n_words && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 200) begin
      errors++;
      $display("FAIL wait_words_timeout: got %0d handshakes expected %0d", hs_cnt, n_words);
    end
  endtask

  task automatic new_test();
    q.delete();
    hs_cnt   = 0;
    done_cnt = 0;
  endtask

  initial begin
    int n;
    int idx;
    load_pattern();

    // reset state, observed before any clock edge
    #2;
    check("rst_tvalid", {31'd0, tvalid}, 32'd0);
    check("rst_tlast", {31'd0, tlast}, 32'd0);
    check("rst_tdata", tdata, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_after_reset", {31'd0, busy}, 32'd0);

    // single pass, tready held high
    new_test();
    tr_mode = 0;
    push_passes(1);
    pulse_start(4'd0);
    wait_stream("single", 1, 300);

    // pseudo-random backpressure
    new_test();
    tr_mode = 1;
    push_passes(1);
    pulse_start(4'd0);
    wait_stream("backpressure", 1, 400);
    check("backpressure_handshakes", 32'(hs_cnt), 32'(NW));
    tr_mode = 0;

    // three passes back to back
    new_test();
    push_passes(3);
    pulse_start(4'd2);
    wait_stream("repeat", 1, 400);
    check("repeat_handshakes", 32'(hs_cnt), 32'(3 * NW));

    // input change and start while busy are ignored
    new_test();
    push_passes(1);
    pulse_start(4'd0);
    wait_words(10);
    @(posedge clk);
    #1;
    sync_word    = '1;
    repeat_count = 4'd15;
    start        = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_stream("snapshot", 1, 300);
    repeat (30) @(negedge clk);
    check("no_second_stream", {31'd0, busy}, 32'd0);
    check("snapshot_handshakes", 32'(hs_cnt), 32'(NW));
    load_pattern();

    // asynchronous reset mid-stream, then restart from word 0
    new_test();
    push_passes(1);
    pulse_start(4'd0);
    wait_words(12);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_tvalid", {31'd0, tvalid}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_tdata", tdata, 32'd0);
    q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("abort_no_done", 32'(done_cnt), 32'd0);
    check("abort_idle", {31'd0, busy}, 32'd0);
    new_test();
    push_passes(1);
    pulse_start(4'd0);
    wait_stream("restart", 1, 300);

    // start presented in the done cycle is accepted
    new_test();
    push_passes(1);
    pulse_start(4'd0);
    n = 0;
    while (!done && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("done_seen", {31'd0, done}, 32'd1);
    push_passes(1);
    repeat_count = 4'd0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    check("start_on_done_tvalid", {31'd0, tvalid}, 32'd1);
    check("start_on_done_word0", tdata, 32'hA500_0000);
    wait_stream("start_on_done", 2, 300);

    // 790 carriers, all ones: last word carries only 22 valid bits
    @(posedge clk);
    #1;
    start790 = 1'b1;
    @(posedge clk);
    #1;
    start790 = 1'b0;
    idx = 0;
    n   = 0;
    while (idx < NW && n < 100) begin
      @(negedge clk);
      n++;
      if (tvalid790 && tready790) begin
        if (idx == 0) check("c790_word0", tdata790, 32'hFFFF_FFFF);
        if (idx == 23) check("c790_word23_tlast", {31'd0, tlast790}, 32'd0);
        if (idx == NW - 1) begin
          check("c790_word24", tdata790, 32'h003F_FFFF);
          check("c790_word24_tlast", {31'd0, tlast790}, 32'd1);
        end
        idx++;
      end
    end
    check("c790_word_count", 32'(idx), 32'(NW));
    @(negedge clk);
    check("c790_done", {31'd0, done790}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
